// File: rtl/div_signed_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_signed_pkg : shared state encoding and error codes for div_signed_seq  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package div_signed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int              ERR_W     = 1;
  localparam logic [ERR_W-1:0] ERR_NONE  = 1'b0;
  localparam logic [ERR_W-1:0] ERR_FAULT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/div_signed_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_signed_seq_if : request/result bundle for div_signed_seq               |
// | error member exists only with DIV_SIGNED_SEQ_ERROR_EN. Rev 1.0             |
// +----------------------------------------------------------------------------+
interface div_signed_seq_if #(
  parameter int DATA_WIDTHA = 16,
  parameter int DATA_WIDTHB = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [DATA_WIDTHA-1:0] dividend;
  logic signed [DATA_WIDTHB-1:0] divisor;
  logic                          out_valid;
  logic signed [DATA_WIDTHA-1:0] quotient;
  logic signed [DATA_WIDTHB-1:0] remainder;
`ifdef DIV_SIGNED_SEQ_ERROR_EN
  logic                          error;

  modport master (
    output in_valid, dividend, divisor,
    input  in_ready, out_valid, quotient, remainder, error
  );
  modport slave (
    input  in_valid, dividend, divisor,
    output in_ready, out_valid, quotient, remainder, error
  );
`else
  modport master (
    output in_valid, dividend, divisor,
    input  in_ready, out_valid, quotient, remainder
  );
  modport slave (
    input  in_valid, dividend, divisor,
    output in_ready, out_valid, quotient, remainder
  );
`endif
endinterface
`default_nettype wire

// File: rtl/div_signed_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_signed_seq : iterative restoring signed divider, one quotient bit/cycle|
// | Optional error output: DIV_SIGNED_SEQ_ERROR_EN. Rev 1.0                    |
// +----------------------------------------------------------------------------+
module div_signed_seq
  import div_signed_pkg::*;
#(
  parameter int DATA_WIDTHA = 16,
  parameter int DATA_WIDTHB = 8
) (
  input  logic           clk,
  input  logic           reset,
  div_signed_seq_if.slave bus
);

  localparam int CNT_W = (DATA_WIDTHA > 1) ? $clog2(DATA_WIDTHA) : 1;

  div_state_t             state_q, state_d;
  logic                   qsign_q, qsign_d;
  logic                   rsign_q, rsign_d;
  logic                   dz_q, dz_d;
  logic [DATA_WIDTHA-1:0] dvd_q, dvd_d;
  logic [DATA_WIDTHB-1:0] dvs_q, dvs_d;
  logic [DATA_WIDTHB:0]   prem_q, prem_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTHA-1:0] quo_q, quo_d;
  logic [DATA_WIDTHB-1:0] rem_q, rem_d;
`ifdef DIV_SIGNED_SEQ_ERROR_EN
  logic                   ovf_q, ovf_d;
  logic [ERR_W-1:0]       err_q, err_d;
`endif

  logic [DATA_WIDTHA-1:0] w_dvd_raw, w_dvd_mag, w_quo;
  logic [DATA_WIDTHB-1:0] w_dvs_raw, w_dvs_mag, w_rem;
  logic [DATA_WIDTHB:0]   w_shift, w_diff;
  logic                   w_ge;

  assign w_dvd_raw = bus.dividend;
  assign w_dvs_raw = bus.divisor;
  // Magnitudes held unsigned so |min| is representable.
  assign w_dvd_mag = w_dvd_raw[DATA_WIDTHA-1] ? -w_dvd_raw : w_dvd_raw;
  assign w_dvs_mag = w_dvs_raw[DATA_WIDTHB-1] ? -w_dvs_raw : w_dvs_raw;

  // prem_q[B] is the bit shifted out; when set the true shifted value exceeds any divisor.
  assign w_shift = {prem_q[DATA_WIDTHB-1:0], dvd_q[DATA_WIDTHA-1]};
  assign w_ge    = prem_q[DATA_WIDTHB] || (w_shift >= {1'b0, dvs_q});
  assign w_diff  = w_shift - {1'b0, dvs_q};

  assign w_quo = qsign_q ? -dvd_q : dvd_q;
  assign w_rem = rsign_q ? -prem_q[DATA_WIDTHB-1:0] : prem_q[DATA_WIDTHB-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      qsign_q     <= 1'b0;
      rsign_q     <= 1'b0;
      dz_q        <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
`ifdef DIV_SIGNED_SEQ_ERROR_EN
      ovf_q       <= 1'b0;
      err_q       <= ERR_NONE;
`endif
    end else begin
      state_q     <= state_d;
      qsign_q     <= qsign_d;
      rsign_q     <= rsign_d;
      dz_q        <= dz_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
`ifdef DIV_SIGNED_SEQ_ERROR_EN
      ovf_q       <= ovf_d;
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    qsign_d     = qsign_q;
    rsign_d     = rsign_q;
    dz_d        = dz_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    quo_d       = quo_q;
    rem_d       = rem_q;
`ifdef DIV_SIGNED_SEQ_ERROR_EN
    ovf_d       = ovf_q;
    err_d       = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          qsign_d = w_dvd_raw[DATA_WIDTHA-1] ^ w_dvs_raw[DATA_WIDTHB-1];
          rsign_d = w_dvd_raw[DATA_WIDTHA-1];
          dz_d    = (w_dvs_raw == '0);
          dvd_d   = w_dvd_mag;
          dvs_d   = w_dvs_mag;
          prem_d  = '0;
          cnt_d   = '0;
`ifdef DIV_SIGNED_SEQ_ERROR_EN
          ovf_d   = (w_dvd_raw == {1'b1, {(DATA_WIDTHA-1){1'b0}}}) && (&w_dvs_raw);
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        // dvd_q doubles as the quotient: dividend bits leave the top, quotient bits enter the bottom.
        dvd_d  = {dvd_q[DATA_WIDTHA-2:0], w_ge};
        prem_d = w_ge ? w_diff : w_shift;
        if (cnt_q == CNT_W'(DATA_WIDTHA - 1)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIX: begin
        quo_d       = dz_q ? '1 : w_quo;
        rem_d       = dz_q ? '0 : w_rem;
        out_valid_d = 1'b1;
`ifdef DIV_SIGNED_SEQ_ERROR_EN
        err_d       = (dz_q || ovf_q) ? ERR_FAULT : ERR_NONE;
`endif
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE) && !reset;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
`ifdef DIV_SIGNED_SEQ_ERROR_EN
  assign bus.error     = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_signed_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_div_signed_seq : directed self-checking bench for div_signed_seq, A=16 B=8|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_div_signed_seq;

  localparam int AW  = 16;
  localparam int BW  = 8;
  localparam int LAT = AW + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  div_signed_seq_if #(.DATA_WIDTHA(AW), .DATA_WIDTHB(BW)) dif();

  div_signed_seq #(
    .DATA_WIDTHA(AW),
    .DATA_WIDTHB(BW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Counts edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_result(output int n, output bit rdy_bad);
    n = 0;
    rdy_bad = 1'b0;
    while (dif.out_valid !== 1'b1 && n < 40) begin
      if (dif.in_ready !== 1'b0) rdy_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input int a, input int b,
                        input int q, input int r, input int e);
    int n;
    bit rdy_bad;
    @(negedge clk);
    check({tag, ".ready"}, dif.in_ready, 1);
    dif.dividend = 16'(a);
    dif.divisor  = 8'(b);
    dif.in_valid = 1'b1;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    dif.dividend = 16'sd1;
    dif.divisor  = 8'sd1;
    wait_result(n, rdy_bad);
    check({tag, ".latency"}, n, LAT);
    check({tag, ".busy"}, rdy_bad, 0);
    check({tag, ".quot"}, dif.quotient, q);
    check({tag, ".rem"}, dif.remainder, r);
`ifdef DIV_SIGNED_SEQ_ERROR_EN
    check({tag, ".err"}, dif.error, e);
`else
    if (e < 0) $display("unexpected error code %0d", e);
`endif
    @(posedge clk); #1;
    check({tag, ".pulse"}, dif.out_valid, 0);
    check({tag, ".hold"}, dif.quotient, q);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  rdy_bad;
    bit  seen;
    time t_prev;
    int  bq [3] = '{14, -14, -333};
    int  br [3] = '{2, -2, 1};
    int  ba [3] = '{100, -100, 1000};
    int  bb [3] = '{7, 7, -3};

    // in_valid asserted while in reset must not be accepted
    dif.in_valid = 1'b1;
    dif.dividend = 16'sd100;
    dif.divisor  = 8'sd7;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", dif.in_ready, 0);
    check("rst.valid", dif.out_valid, 0);
    check("rst.quot", dif.quotient, 0);
    check("rst.rem", dif.remainder, 0);
`ifdef DIV_SIGNED_SEQ_ERROR_EN
    check("rst.err", dif.error, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    dif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.noaccept", dif.in_ready, 1);

    run_op("p_p",     100,    7,    14,   2, 0);
    run_op("n_p",    -100,    7,   -14,  -2, 0);
    run_op("p_n",     100,   -7,   -14,   2, 0);
    run_op("n_n",    -100,   -7,    14,  -2, 0);
    run_op("ovf",  -32768,   -1, -32768,  0, 1);
    run_op("min_m", -32768, -128,  256,   0, 0);
    run_op("min_7", -32768,    7, -4681, -1, 0);
    run_op("dz_p",      5,    0,    -1,   0, 1);
    run_op("dz_n",     -5,    0,    -1,   0, 1);
    run_op("small",    -1,  127,     0,  -1, 0);
    run_op("maxb",    127, -128,     0, 127, 0);
    run_op("maxa",  32767,    1, 32767,   0, 0);

    // back-to-back with in_valid held; inputs scrambled while busy
    @(negedge clk);
    dif.dividend = 16'(ba[0]);
    dif.divisor  = 8'(bb[0]);
    dif.in_valid = 1'b1;
    @(posedge clk); #1;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      dif.dividend = 16'sd5;
      dif.divisor  = 8'sd1;
      wait_result(n, rdy_bad);
      check($sformatf("b2b%0d.latency", k), n, LAT);
      check($sformatf("b2b%0d.busy", k), rdy_bad, 0);
      check($sformatf("b2b%0d.quot", k), dif.quotient, bq[k]);
      check($sformatf("b2b%0d.rem", k), dif.remainder, br[k]);
      check($sformatf("b2b%0d.ready", k), dif.in_ready, 1);
      if (k > 0) check($sformatf("b2b%0d.gap", k), int'(($time - t_prev) / 10), AW + 2);
      t_prev = $time;
      if (k < 2) begin
        dif.dividend = 16'(ba[k+1]);
        dif.divisor  = 8'(bb[k+1]);
      end else begin
        dif.in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end

    // reset in the middle of CALC aborts the operation
    @(negedge clk);
    dif.dividend = 16'sd100;
    dif.divisor  = 8'sd7;
    dif.in_valid = 1'b1;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort.quot", dif.quotient, 0);
    check("abort.rem", dif.remainder, 0);
    check("abort.valid", dif.out_valid, 0);
    check("abort.ready_in_rst", dif.in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (dif.out_valid === 1'b1) seen = 1'b1;
    end
    check("abort.no_valid", seen, 0);
    check("abort.ready", dif.in_ready, 1);
    run_op("after", 100, 7, 14, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
